mux2_arbiter: RTL and testbench
===============================

MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 1: data width of in0, in1 and out.
REQ-002 SHALL have parameter MAX_HOLD, default 4: maximum cycles a grant is held while the other requester waits; legal range 2..255.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port: req0  input  1  requester 0 wants the shared output.
REQ-007 SHALL have port: req1  input  1  requester 1 wants the shared output.
REQ-008 SHALL have port: in0  input  WIDTH  requester 0 data.
REQ-009 SHALL have port: in1  input  WIDTH  requester 1 data.
REQ-010 SHALL have port: gnt0  output  1  requester 0 owns the output (registered).
REQ-011 SHALL have port: gnt1  output  1  requester 1 owns the output (registered).
REQ-012 SHALL have port: select  output  1  registered mux select; 0 = in0, 1 = in1.
REQ-013 SHALL have port: out  output  WIDTH  shared output.
REQ-014 SHALL have port: busy  output  1  high when either grant is high.

Function
REQ-015 SHALL implement an FSM with states IDLE, GRANT0 and GRANT1; gnt0 = (state==GRANT0), gnt1 = (state==GRANT1), and gnt0 and gnt1 are never high together.
REQ-016 SHALL drive out = in0 in GRANT0, out = in1 in GRANT1 and out = all zeros in IDLE, combinationally from the registered state.
REQ-017 SHALL hold select at its last granted value while in IDLE.
REQ-018 SHALL grant with one-cycle latency: a req sampled high at edge N gives gnt high from edge N onward.
REQ-019 SHALL keep a last-granted pointer; in IDLE with req0 and req1 both high, the requester not pointed to wins, and the pointer updates on every grant.
REQ-020 SHALL, in IDLE with exactly one req high, grant that requester regardless of the pointer.
REQ-021 SHALL, in GRANTx when reqx drops, move at the same edge directly to GRANTy if reqy is high, with no IDLE bubble; otherwise it SHALL move to IDLE.
REQ-022 SHALL have a hold counter of ceil(log2(MAX_HOLD)) bits that clears on every grant change and increments each cycle in GRANTx, saturating at MAX_HOLD-1.
REQ-023 SHALL treat a req glitch as a release: a req low for one sampled edge ends that grant.
REQ-024 SHALL treat out-of-range or X inputs as don't-care for data; only req0 and req1 affect state.

Reset
REQ-025 SHALL, on rst high at a rising edge, set state = IDLE, gnt0 = 0, gnt1 = 0, busy = 0, select = 0, counter = 0, and pointer = 1 (req0 wins the first tie).
REQ-026 SHALL let rst take priority over all requests; reset mid-grant drops the grant at that edge, and out = 0 from that edge.
REQ-027 SHALL resume arbitration at the first edge where rst is low.

Configuration
REQ-028 SHALL, with macro MUX2_ARBITER_TIMEOUT_EN defined, preempt in GRANTx when counter == MAX_HOLD-1 and reqy is high, moving to GRANTy at that edge so that a contested grant lasts exactly MAX_HOLD cycles.
REQ-029 SHALL, with MUX2_ARBITER_TIMEOUT_EN defined and reqy low at saturation, keep GRANTx, and switch at the first edge where reqy is high.
REQ-030 SHALL, without MUX2_ARBITER_TIMEOUT_EN, have no preemption: a grant ends only on req drop or reset, and the counter may be omitted.

Verification
REQ-031 SHALL check reset: rst=1 for 2 cycles with req0=req1=1 -> gnt0=gnt1=0, select=0, out=0; rst low -> gnt0=1 after 1 edge.
REQ-032 SHALL check a single requester: req1=1 for 3 cycles, in1=1, in0=0 -> gnt1=1, select=1, out=1 for 3 cycles, then IDLE, out=0, and select stays 1.
REQ-033 SHALL check a tie after reset: req0=req1=1 from IDLE -> GRANT0; drop req0 -> GRANT1 at the next edge with no IDLE cycle.
REQ-034 SHALL check timeout with the macro defined and MAX_HOLD=4: req0 held, req1 raised 1 cycle later -> gnt0 high exactly 4 cycles, then gnt1.
REQ-035 SHALL check the same stimulus without the macro: gnt0 stays high until req0 drops, and gnt1 asserts at that edge.
REQ-036 SHALL check reset mid-grant: rst pulse during GRANT1 -> gnt1=0 and out=0 at that edge, and pointer=1 afterwards, so a tie grants req0.

Source files
------------

// File: rtl/mux2_arbiter.sv
// Two-requester output arbiter: round-robin tie-break, direct hand-over, registered grants.
// Optional hold-limit preemption is enabled by defining MUX2_ARBITER_TIMEOUT_EN.
module mux2_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             select,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   ptr;
  logic   hold_sat;

`ifdef MUX2_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt;

  assign hold_sat = (hold_cnt == HOLD_LAST);

  // Counts cycles of the current grant; any state change restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state_next != state) begin
      hold_cnt <= '0;
    end else if ((state != IDLE) && !hold_sat) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end
`else
  assign hold_sat = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          // ptr names the last winner, so the other side takes the tie.
          state_next = ptr ? GRANT0 : GRANT1;
        end else if (req0) begin
          state_next = GRANT0;
        end else if (req1) begin
          state_next = GRANT1;
        end
      end
      GRANT0: begin
        if (!req0) begin
          state_next = req1 ? GRANT1 : IDLE;
        end else if (req1 && hold_sat) begin
          state_next = GRANT1;
        end
      end
      GRANT1: begin
        if (!req1) begin
          state_next = req0 ? GRANT0 : IDLE;
        end else if (req0 && hold_sat) begin
          state_next = GRANT0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= 1'b1;
      select <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == GRANT0) begin
        ptr    <= 1'b0;
        select <= 1'b0;
      end else if (state_next == GRANT1) begin
        ptr    <= 1'b1;
        select <= 1'b1;
      end
    end
  end

  assign gnt0 = (state == GRANT0);
  assign gnt1 = (state == GRANT1);
  assign busy = gnt0 | gnt1;

  always_comb begin
    out = '0;
    case (state)
      GRANT0:  out = in0;
      GRANT1:  out = in1;
      default: out = '0;
    endcase
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter (WIDTH=8, MAX_HOLD=4); expectations follow
// MUX2_ARBITER_TIMEOUT_EN when it is defined for the build.
module tb_mux2_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             gnt0;
  logic             gnt1;
  logic             select;
  logic [WIDTH-1:0] out;
  logic             busy;

  int tests = 0;
  int fails = 0;

  // {gnt0, gnt1, select, busy, out}
  logic [11:0] obs;
  logic [11:0] exp_v;
  assign obs = {gnt0, gnt1, select, busy, out};

  mux2_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .req1   (req1),
    .in0    (in0),
    .in1    (in1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .select (select),
    .out    (out),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; in0 = 8'hA5; in1 = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      step();
      exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL reset_hold[%0d] got %h want %h", i, obs, exp_v);
      end
    end
    rst = 1'b0;
    step();
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL reset_release got %h want %h", obs, exp_v);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL reset_idle got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_single();
    req1 = 1'b1; in1 = 8'h01; in0 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 8'h01};
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL single_gnt1[%0d] got %h want %h", i, obs, exp_v);
      end
    end
    req1 = 1'b0;
    step();
    exp_v = {1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL single_idle_select got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    step();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; in0 = 8'h5A; in1 = 8'hC3;
    step();
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL tie_gnt0 got %h want %h", obs, exp_v);
    end
    in0 = 8'h77;
    #1;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 8'h77};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL tie_data_follow got %h want %h", obs, exp_v);
    end
    req0 = 1'b0;
    step();
    exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 8'hC3};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL handover_gnt1 got %h want %h", obs, exp_v);
    end
    req1 = 1'b0;
    step();
  endtask

  task automatic test_pointer();
    // Grant req0 alone so the pointer names 0; the next tie must go to req1.
    req0 = 1'b1; req1 = 1'b0; in0 = 8'h11; in1 = 8'h22;
    step();
    req0 = 1'b0;
    step();
    req0 = 1'b1; req1 = 1'b1;
    step();
    exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 8'h22};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL pointer_tie_gnt1 got %h want %h", obs, exp_v);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    logic exp_g0;
    req0 = 1'b1; req1 = 1'b0; in0 = 8'h0F; in1 = 8'hF0;
    step();
    tests++;
    if (gnt0 !== 1'b1) begin
      fails++;
      $display("FAIL timeout_start gnt0 got %b want 1", gnt0);
    end
    req1 = 1'b1;
    for (int i = 1; i < 8; i++) begin
      step();
`ifdef MUX2_ARBITER_TIMEOUT_EN
      exp_g0 = (i < MAX_HOLD);
`else
      exp_g0 = 1'b1;
`endif
      tests++;
      if ({gnt0, gnt1} !== {exp_g0, ~exp_g0}) begin
        fails++;
        $display("FAIL timeout_cycle[%0d] gnt0/gnt1 got %b%b want %b%b",
                 i, gnt0, gnt1, exp_g0, ~exp_g0);
      end
    end
`ifndef MUX2_ARBITER_TIMEOUT_EN
    req0 = 1'b0;
    step();
    exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 8'hF0};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL notimeout_release got %h want %h", obs, exp_v);
    end
`endif
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    logic exp_g0;
    req0 = 1'b1; req1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if (gnt0 !== 1'b1) begin
        fails++;
        $display("FAIL sat_hold[%0d] gnt0 got %b want 1", i, gnt0);
      end
    end
    req1 = 1'b1;
    step();
`ifdef MUX2_ARBITER_TIMEOUT_EN
    exp_g0 = 1'b0;
`else
    exp_g0 = 1'b1;
`endif
    tests++;
    if ({gnt0, gnt1} !== {exp_g0, ~exp_g0}) begin
      fails++;
      $display("FAIL sat_contest gnt0/gnt1 got %b%b want %b%b",
               gnt0, gnt1, exp_g0, ~exp_g0);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    req0 = 1'b0; req1 = 1'b1; in0 = 8'h96; in1 = 8'h69;
    step();
    exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 8'h69};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL mid_pre_gnt1 got %h want %h", obs, exp_v);
    end
    rst = 1'b1; req0 = 1'b1;
    step();
    exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL mid_reset_drop got %h want %h", obs, exp_v);
    end
    rst = 1'b0;
    step();
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 8'h96};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL mid_tie_gnt0 got %h want %h", obs, exp_v);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; in0 = '0; in1 = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_pointer();
    test_timeout();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
